mem_port_arbiter4: RTL and testbench

Round-robin arbiter and sequencer for a shared 4-input resource in the pipelined CPU. Typical resources are the unified memory port or a shared functional unit fed through a 4:1 select mux. It accepts up to four requests and grants exactly one requester at a time. It holds the grant until the resource signals completion, the requester withdraws, or a watchdog timeout fires. It drives the 2-bit `sel` of the downstream 4:1 mux directly.

---
 rtl/mem_port_arbiter4.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter4.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter4.sv
// mem_port_arbiter4
//   Round-robin arbiter and sequencer for a shared 4-input resource (memory
//   port or shared functional unit behind a 4:1 mux). One requester holds the
//   grant until the resource completes, the requester withdraws, or the
//   watchdog force-releases it after TIMEOUT cycles.
//
// Parameters
//   TIMEOUT      maximum hold cycles per grant (0 disables the watchdog)
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req[3:0]     request lines, one per requester
//   done         one-cycle completion pulse from the resource
//   grant[3:0]   registered one-hot grant, zero when idle
//   sel[1:0]     encoded grant index, held across idle for a stable mux
//   busy         high while a grant is active
//   timeout_err  one-cycle pulse after a watchdog-forced release
module mem_port_arbiter4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic        WD_ON   = (TIMEOUT != 0);
  localparam logic [15:0] CNT_END = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  grant_reg, grant_next;
  logic [1:0]  sel_reg, sel_next;
  logic        busy_reg, busy_next;
  logic        terr_reg, terr_next;
  logic [1:0]  last_reg, last_next;
  logic [15:0] cnt_reg, cnt_next;

  // Round-robin scan: candidate gi is (last + gi + 1) mod 4, so the most
  // recently granted index is always examined last.
  logic [1:0] cand_idx [4];
  logic [3:0] rot_req;
  logic       win_any;
  logic [1:0] win_idx;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign cand_idx[gi] = last_reg + 2'(gi + 1);
    assign rot_req[gi]  = req[cand_idx[gi]];
  end

  always_comb begin
    win_any = |req;
    win_idx = cand_idx[3];
    if (rot_req[0])      win_idx = cand_idx[0];
    else if (rot_req[1]) win_idx = cand_idx[1];
    else if (rot_req[2]) win_idx = cand_idx[2];
  end

  // Release conditions while granted. The watchdog only counts as the cause
  // when neither completion nor withdrawal happened in the same cycle.
  logic abort_ev, wd_hit, release_ev, wd_only;

  always_comb begin
    abort_ev   = ~req[sel_reg];
    wd_hit     = WD_ON && (cnt_reg == CNT_END);
    release_ev = done | abort_ev | wd_hit;
    wd_only    = wd_hit & ~done & ~abort_ev;
  end

  // State register (also holds all registered outputs and internal state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= 4'b0000;
      sel_reg   <= 2'b00;
      busy_reg  <= 1'b0;
      terr_reg  <= 1'b0;
      last_reg  <= 2'b11;
      cnt_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
      terr_reg  <= terr_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_any) state_next = GRANT;
      GRANT:   if (release_ev && !win_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath logic
  logic do_grant;

  always_comb begin
    grant_next = grant_reg;
    sel_next   = sel_reg;
    busy_next  = busy_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    terr_next  = 1'b0;
    do_grant   = 1'b0;

    case (state_reg)
      IDLE: begin
        do_grant = win_any;
      end
      GRANT: begin
        terr_next = wd_only;
        if (release_ev) begin
          do_grant = win_any;
          if (!win_any) begin
            grant_next = 4'b0000;
            busy_next  = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: ;
    endcase

    // Back-to-back handover: the new winner is loaded in the release cycle.
    if (do_grant) begin
      grant_next = 4'b0001 << win_idx;
      sel_next   = win_idx;
      busy_next  = 1'b1;
      last_next  = win_idx;
      cnt_next   = 16'd0;
    end
  end

  assign grant       = grant_reg;
  assign sel         = sel_reg;
  assign busy        = busy_reg;
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
module tb_mem_port_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  mem_port_arbiter4 #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then read 1 time unit after the edge.
  // Every cycle also checks the structural invariants on grant/busy.
  task automatic tick();
    @(posedge clk);
    #1;
    n_cmp++;
    assert (($countones(grant) <= 1) && ((grant != 4'b0000) === busy)) else begin
      n_mis++;
      $error("FAIL invariant: observed grant=%b busy=%b, required one-hot-or-zero grant with busy==|grant",
             grant, busy);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic te);
    n_cmp++;
    assert ({grant, sel, busy, timeout_err} === {g, s, b, te}) else begin
      n_mis++;
      $error("FAIL %s: observed grant=%b sel=%0d busy=%b terr=%b, required grant=%b sel=%0d busy=%b terr=%b",
             tag, grant, sel, busy, timeout_err, g, s, b, te);
    end
    $display("step %-14s req=%b done=%b -> grant=%b sel=%0d busy=%b terr=%b",
             tag, req, done, grant, sel, busy, timeout_err);
  endtask

  initial begin
    // ---- Reset with all requests and done asserted ----
    rst = 1'b1; req = 4'b1111; done = 1'b1;
    tick(); tick();
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; done = 1'b0;
    tick();
    chk("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    chk("first_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ---- Single request, done two cycles later ----
    req = 4'b0100;
    tick();
    chk("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_done", 4'b0000, 2'd2, 1'b0, 1'b0);

    // ---- Reset while idle to return priority to requester 0 ----
    rst = 1'b1; req = 4'b1111;
    tick();
    chk("reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // ---- Round robin, all requesting, done every third cycle ----
    tick();
    chk("rr_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); tick(); done = 1'b1;
    tick(); done = 1'b0;
    chk("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); tick(); done = 1'b1;
    tick(); done = 1'b0;
    chk("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); tick(); done = 1'b1;
    tick(); done = 1'b0;
    chk("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // ---- Wrap 3 -> 0 and skip over idle requesters ----
    tick(); tick(); done = 1'b1; req = 4'b1001;
    tick(); done = 1'b0;
    chk("wrap_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    chk("skip_to_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000; done = 1'b1;
    tick(); done = 1'b0;
    chk("wrap_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    // ---- Watchdog: hold exactly 8 cycles then force release ----
    req = 4'b0010;
    tick();
    chk("wd_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("wd_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk("wd_fire", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    chk("wd_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);

    // ---- Watchdog cycle coinciding with done: normal release ----
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wd2_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick(); done = 1'b0;
    chk("wd2_done", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk("wd2_abort", 4'b0000, 2'd1, 1'b0, 1'b0);

    // ---- Abort: requester 2 withdraws while 0 waits ----
    req = 4'b0100;
    tick();
    chk("abort_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk("abort_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    chk("abort_switch", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk("abort_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ---- Reset in the middle of a grant ----
    req = 4'b1000;
    tick();
    chk("pre_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1; done = 1'b1; req = 4'b1111;
    tick();
    chk("rst_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; done = 1'b0;
    tick();
    chk("post_rst_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // ---- done while idle is ignored ----
    req = 4'b0000;
    tick();
    chk("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
